// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 engine: shift-add multiply and restoring divide, one bit per
// cycle over unsigned magnitudes, with the sign applied in a FIX cycle.
// Division by zero and signed overflow complete through a one-cycle fast path.
module muldiv_seq #(
  parameter int RegBusWidth = 32,
  parameter int CntWidth    = 6
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start_i,
  input  logic [2:0]             op_i,
  input  logic [RegBusWidth-1:0] rs1_i,
  input  logic [RegBusWidth-1:0] rs2_i,
  input  logic                   flush_i,
  output logic [RegBusWidth-1:0] result_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   stallreq_o
);

  localparam int W = RegBusWidth;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [W-1:0]        a_mag, b_mag;
  logic                neg_q;
  logic [CntWidth-1:0] cnt;
  logic [2*W-1:0]      prod;
  logic [W:0]          rem;
  logic [W-1:0]        quo;

  // Operand decode for the start cycle
  logic         rs1_sgn, rs2_sgn, s1, s2, sign_in;
  logic [W-1:0] mag1, mag2;
  logic         div_zero, div_ovf, fast, go;
  logic [W-1:0] fast_res;

  // Funct3 signedness, magnitudes, result sign and fast-path detection
  always_comb begin
    rs1_sgn  = op_i[2] ? ~op_i[0] : (op_i != 3'd3);
    rs2_sgn  = op_i[2] ? ~op_i[0] : ~op_i[1];
    s1       = rs1_sgn & rs1_i[W-1];
    s2       = rs2_sgn & rs2_i[W-1];
    mag1     = s1 ? -rs1_i : rs1_i;
    mag2     = s2 ? -rs2_i : rs2_i;
    // remainder takes the dividend's sign; everything else the xor
    sign_in  = (op_i[2] & op_i[1]) ? s1 : (s1 ^ s2);
    div_zero = op_i[2] & (rs2_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (rs1_i == {1'b1, {(W-1){1'b0}}}) & (&rs2_i);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = op_i[1] ? rs1_i : '1;
    else          fast_res = op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    go       = (state == IDLE) & start_i & ~flush_i;
  end

  // One iteration of the multiply and divide engines
  logic [W:0]   mul_sum;
  logic [2*W-1:0] prod_step;
  logic [W:0]   rem_sh;
  logic [W+1:0] rem_diff;
  logic         q_bit;

  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_mag} : '0);
    prod_step = {mul_sum, prod[W-1:1]};
    rem_sh    = (rem << 1) | {{W{1'b0}}, quo[W-1]};
    rem_diff  = {1'b0, rem_sh} - {2'b0, b_mag};
    q_bit     = ~rem_diff[W+1];
  end

  // Sign correction and result select for the FIX cycle
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -quo : quo;
    rem_s  = neg_q ? -rem[W-1:0] : rem[W-1:0];
    case (op_q)
      3'd0:          fix_res = prod_s[W-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_s[2*W-1:W];
      3'd4, 3'd5:    fix_res = quo_s;
      default:       fix_res = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and status outputs; flush overrides everything
  always_comb begin
    state_nxt  = state;
    busy_o     = (state != IDLE);
    done_o     = (state == DONE);
    stallreq_o = go | (state == CALC) | (state == FIX);
    case (state)
      IDLE: if (go) state_nxt = fast ? DONE : CALC;
      CALC: if (cnt == CntWidth'(W-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q     <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      neg_q    <= 1'b0;
      cnt      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      result_o <= '0;
    end else begin
      if (go) begin
        op_q  <= op_i;
        a_mag <= mag1;
        b_mag <= mag2;
        neg_q <= sign_in;
        cnt   <= '0;
        prod  <= {{W{1'b0}}, mag2};
        quo   <= mag1;
        rem   <= '0;
        if (fast) result_o <= fast_res;
      end else if (state == CALC && !flush_i) begin
        cnt <= cnt + 1'b1;
        if (op_q[2]) begin
          rem <= q_bit ? rem_diff[W:0] : rem_sh;
          quo <= {quo[W-2:0], q_bit};
        end else begin
          prod <= prod_step;
        end
      end else if (state == FIX && !flush_i) begin
        result_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M vectors, randomized ops against an
// arithmetic reference, cycle-exact latency/stall checks, flush and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        done_o, busy_o, stallreq_o;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] last_res = '0;

  muldiv_seq dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .result_o(result_o), .done_o(done_o), .busy_o(busy_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // One operation: start at cycle 0, check stall each cycle, latency, result.
  // With disturb set, start_i is pulsed during CALC and in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string name);
    logic [31:0] exp_res, got;
    int lat, done_cyc, stall_bad, extra;
    exp_res = ref_model(op, a, b);
    lat = is_fast(op, a, b) ? 1 : 34;
    done_cyc = -1; stall_bad = 0; extra = 0; got = '0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    #1;
    if (stallreq_o !== 1'b1) stall_bad++;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      rs1_i = $urandom; rs2_i = $urandom; op_i = 3'($urandom_range(0, 7));
      if (disturb && c == 5) start_i = 1'b1;
      #1;
      if (stallreq_o !== (c < lat)) stall_bad++;
      if (done_o === 1'b1) begin
        done_cyc = c; got = result_o;
        if (disturb) start_i = 1'b1;
      end
    end
    vectors++;
    if (done_cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (op %0d a %h b %h)", name, done_cyc, lat, op, a, b);
    end
    vectors++;
    if (got !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h (op %0d a %h b %h)", name, got, exp_res, op, a, b);
    end
    vectors++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL %s stallreq: got %0d bad cycles expected 0", name, stall_bad);
    end
    last_res = exp_res;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    vectors++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp_res) begin
      errors++;
      $display("FAIL %s after-done: got done %b busy %b res %h expected 0 0 %h",
               name, done_o, busy_o, result_o, exp_res);
    end
    if (disturb) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done_o === 1'b1) extra++;
      end
      vectors++;
      if (extra != 0 || result_o !== exp_res) begin
        errors++;
        $display("FAIL %s ignored-start: got %0d extra done, res %h expected 0, %h",
                 name, extra, result_o, exp_res);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (result_o !== 32'h0 || done_o !== 1'b0 || busy_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: got res %h done %b busy %b stall %b expected all 0",
               result_o, done_o, busy_o, stallreq_o);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mul");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "remu");
  endtask

  task automatic test_fast_path();
    run_op(3'd5, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 1'b0, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(3'd6, 32'h8000_0000, 32'd0, 1'b0, "rem_by0");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, 1'b0, "random");
    end
  endtask

  task automatic test_flush();
    int seen_done;
    logic [31:0] held;
    held = last_res; seen_done = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      flush_i = (c == 10);
      #1;
      if (done_o === 1'b1) seen_done++;
    end
    vectors++;
    if (busy_o !== 1'b0 || seen_done != 0 || result_o !== held) begin
      errors++;
      $display("FAIL flush: got busy %b done %0d res %h expected 0 0 %h",
               busy_o, seen_done, result_o, held);
    end
    run_op(3'd5, 32'd1000, 32'd3, 1'b0, "after_flush");
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'h1234_5678; rs2_i = 32'h9abc_def1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if (result_o !== 32'h0 || done_o !== 1'b0 || busy_o !== 1'b0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got res %h done %b busy %b stall %b expected all 0",
               result_o, done_o, busy_o, stallreq_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", seen_done);
    end
    last_res = '0;
  endtask

  task automatic test_ignore_start();
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, "ignore_start_mul");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, "ignore_start_rem");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_path();
    test_flush();
    test_reset_mid();
    test_ignore_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
